// File: rtl/ines_rom_loader.sv
// iNES image loader: validates the 16-byte header of an NROM image, then streams
// trainer/PRG/CHR bytes into the ROM programmer port while holding the console in reset.
module ines_rom_loader #(
  parameter int PRG_MAX_BANKS = 2,
  parameter int CHR_MAX_BANKS = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        prg_rom_prgmr_wren,
  output logic        chr_rom_prgmr_wren,
  output logic [15:0] rom_prgmr_addr,
  output logic [7:0]  rom_prgmr_data,
  output logic        is_chr_ram,
  output logic        mirroring_mode,
  output logic        prg_single_bank,
  output logic        nes_reset,
  output logic        nes_enable,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  error_code
);

  typedef enum logic [2:0] {IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR} state_t;
  typedef enum logic [2:0] {ERR_NONE, ERR_MAGIC, ERR_PRG, ERR_CHR, ERR_MAPPER} err_t;

  localparam logic [7:0] PRG_MAX = 8'(PRG_MAX_BANKS);
  localparam logic [7:0] CHR_MAX = 8'(CHR_MAX_BANKS);

  state_t      state;
  err_t        hdr_err;
  logic [3:0]  hdr_idx;
  logic [7:0]  prg_banks;
  logic [7:0]  chr_banks;
  logic        has_trainer;
  logic        mirror_hdr;
  logic [3:0]  mapper_lo;
  logic [3:0]  mapper_hi;
  logic [15:0] cnt;
  logic [15:0] prg_last;
  logic [15:0] chr_last;
  logic        accept;

  function automatic logic [7:0] magic_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h4E;
      2'd1:    return 8'h45;
      2'd2:    return 8'h53;
      default: return 8'h1A;
    endcase
  endfunction

  // A start pulse takes precedence over a byte offered in the same cycle.
  assign byte_ready = (state inside {HEADER, TRAINER, PRG, CHR}) && !start;
  assign accept     = byte_valid && byte_ready;

  // Bank counts are validated to fit, so size-1 never needs a 17th bit.
  assign prg_last = {prg_banks[1:0], 14'd0} - 16'd1;
  assign chr_last = {chr_banks[2:0], 13'd0} - 16'd1;

  always_comb begin
    // NOTE: default first so every path assigns hdr_err and no latch is inferred.
    hdr_err = ERR_NONE;
    if (hdr_idx < 4'd4) begin
      if (byte_data != magic_byte(hdr_idx[1:0])) hdr_err = ERR_MAGIC;
    end else if (hdr_idx == 4'd15) begin
      if (prg_banks == 8'd0 || prg_banks > PRG_MAX) hdr_err = ERR_PRG;
      else if (chr_banks > CHR_MAX)                 hdr_err = ERR_CHR;
      else if ({mapper_hi, mapper_lo} != 8'd0)      hdr_err = ERR_MAPPER;
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state              <= IDLE;
      hdr_idx            <= '0;
      prg_banks          <= '0;
      chr_banks          <= '0;
      has_trainer        <= 1'b0;
      mirror_hdr         <= 1'b0;
      mapper_lo          <= '0;
      mapper_hi          <= '0;
      cnt                <= '0;
      prg_rom_prgmr_wren <= 1'b0;
      chr_rom_prgmr_wren <= 1'b0;
      rom_prgmr_addr     <= '0;
      rom_prgmr_data     <= '0;
      is_chr_ram         <= 1'b0;
      mirroring_mode     <= 1'b0;
      prg_single_bank    <= 1'b0;
      nes_reset          <= 1'b1;
      nes_enable         <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      error_code         <= ERR_NONE;
    end else begin
      prg_rom_prgmr_wren <= 1'b0;
      chr_rom_prgmr_wren <= 1'b0;
      if (start) begin
        state           <= HEADER;
        hdr_idx         <= '0;
        cnt             <= '0;
        done            <= 1'b0;
        error           <= 1'b0;
        error_code      <= ERR_NONE;
        is_chr_ram      <= 1'b0;
        mirroring_mode  <= 1'b0;
        prg_single_bank <= 1'b0;
        nes_reset       <= 1'b1;
        nes_enable      <= 1'b0;
        busy            <= 1'b1;
      end else if (accept) begin
        case (state)
          HEADER: begin
            hdr_idx <= hdr_idx + 4'd1;
            if (hdr_err != ERR_NONE) begin
              state      <= ERROR;
              error      <= 1'b1;
              error_code <= hdr_err;
              busy       <= 1'b0;
            end else begin
              case (hdr_idx)
                4'd4: prg_banks <= byte_data;
                4'd5: chr_banks <= byte_data;
                4'd6: begin
                  mirror_hdr  <= byte_data[0];
                  has_trainer <= byte_data[2];
                  mapper_lo   <= byte_data[7:4];
                end
                4'd7: mapper_hi <= byte_data[7:4];
                4'd15: begin
                  is_chr_ram      <= (chr_banks == 8'd0);
                  mirroring_mode  <= mirror_hdr;
                  prg_single_bank <= (prg_banks == 8'd1);
                  cnt             <= '0;
                  state           <= has_trainer ? TRAINER : PRG;
                end
                default: ;
              endcase
            end
          end
          TRAINER: begin
            if (cnt[8:0] == 9'h1FF) begin
              cnt   <= '0;
              state <= PRG;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          PRG, CHR: begin
            prg_rom_prgmr_wren <= (state == PRG);
            chr_rom_prgmr_wren <= (state == CHR);
            rom_prgmr_addr     <= cnt;
            rom_prgmr_data     <= byte_data;
            if (cnt == ((state == PRG) ? prg_last : chr_last)) begin
              cnt <= '0;
              if (state == PRG && !is_chr_ram) begin
                state <= CHR;
              end else begin
                state      <= DONE;
                done       <= 1'b1;
                busy       <= 1'b0;
                nes_reset  <= 1'b0;
                nes_enable <= 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ines_rom_loader.sv
// Scoreboard bench for ines_rom_loader: expected ROM writes are queued as bytes are
// accepted and popped by a monitor whenever a write strobe is seen.
module tb_ines_rom_loader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        prg_rom_prgmr_wren;
  logic        chr_rom_prgmr_wren;
  logic [15:0] rom_prgmr_addr;
  logic [7:0]  rom_prgmr_data;
  logic        is_chr_ram;
  logic        mirroring_mode;
  logic        prg_single_bank;
  logic        nes_reset;
  logic        nes_enable;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  error_code;

  ines_rom_loader dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .start              (start),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .byte_ready         (byte_ready),
    .prg_rom_prgmr_wren (prg_rom_prgmr_wren),
    .chr_rom_prgmr_wren (chr_rom_prgmr_wren),
    .rom_prgmr_addr     (rom_prgmr_addr),
    .rom_prgmr_data     (rom_prgmr_data),
    .is_chr_ram         (is_chr_ram),
    .mirroring_mode     (mirroring_mode),
    .prg_single_bank    (prg_single_bank),
    .nes_reset          (nes_reset),
    .nes_enable         (nes_enable),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .error_code         (error_code)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] H_NROM256 = 128'h4E45531A_02010100_00000000_00000000;
  localparam logic [127:0] H_TRAINER = 128'h4E45531A_01000400_00000000_00000000;
  localparam logic [127:0] H_NROM128 = 128'h4E45531A_01010100_00000000_00000000;
  localparam logic [127:0] H_BADMAG  = 128'h4E45581A_02010100_00000000_00000000;
  localparam logic [127:0] H_PRG3    = 128'h4E45531A_03010000_00000000_00000000;
  localparam logic [127:0] H_CHR2    = 128'h4E45531A_01020000_00000000_00000000;
  localparam logic [127:0] H_MAPPER  = 128'h4E45531A_01011000_00000000_00000000;
  localparam logic [127:0] H_PRIO    = 128'h4E45531A_00011000_00000000_00000000;

  int vectors     = 0;
  int miscompares = 0;
  bit stalled     = 1'b0;
  logic [25:0] exp_q[$];  // {prg_wren, chr_wren, addr, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] prg_byte(input int a);
    logic [15:0] v;
    v = a[15:0];
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] chr_byte(input int a);
    logic [15:0] v;
    v = a[15:0];
    return (v[7:0] + {v[12:8], 3'b000}) ^ 8'hC3;
  endfunction

  always @(posedge CLK) begin : monitor
    logic [25:0] e;
    #1;
    if (prg_rom_prgmr_wren || chr_rom_prgmr_wren) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {30'd0, prg_rom_prgmr_wren, chr_rom_prgmr_wren}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write", {6'd0, prg_rom_prgmr_wren, chr_rom_prgmr_wren, rom_prgmr_addr, rom_prgmr_data},
              {6'd0, e});
      end
    end
  end

  // Entered at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap, input bit has_wr, input logic [25:0] wr);
    if (stalled) return;
    for (int t = 0; t < 64; t++) begin
      byte_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      byte_data  = b;
      #1;
      if (byte_valid && byte_ready) begin
        if (has_wr) exp_q.push_back(wr);
        @(negedge CLK);
        return;
      end
      @(negedge CLK);
    end
    check("handshake_timeout", {31'd0, byte_ready}, 32'd1);
    stalled = 1'b1;
  endtask

  task automatic send_header(input logic [127:0] h, input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(h[127-8*i -: 8], gap, 1'b0, '0);
  endtask

  task automatic send_trainer();
    for (int i = 0; i < 512; i++) send_byte(8'hEE, 1'b0, 1'b0, '0);
  endtask

  task automatic send_prg(input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(prg_byte(i), gap, 1'b1, {2'b10, 16'(i), prg_byte(i)});
  endtask

  task automatic send_chr(input int n, input bit gap);
    for (int i = 0; i < n; i++) send_byte(chr_byte(i), gap, 1'b1, {2'b01, 16'(i), chr_byte(i)});
  endtask

  task automatic pulse_start();
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge CLK);
    start      = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"},
          {20'd0, nes_reset, nes_enable, busy, done, error, error_code,
           is_chr_ram, mirroring_mode, prg_single_bank, byte_ready},
          {20'd0, 1'b1, 11'd0});
    check({tag, "_wren"}, {30'd0, prg_rom_prgmr_wren, chr_rom_prgmr_wren}, 32'd0);
    check({tag, "_addr_data"}, {8'd0, rom_prgmr_addr, rom_prgmr_data}, 32'd0);
  endtask

  task automatic check_done(input string tag, input bit chr_ram, input bit mirror, input bit single);
    check({tag, "_done"}, {29'd0, done, nes_enable, nes_reset}, {29'd0, 3'b110});
    check({tag, "_busy_rdy_err"}, {29'd0, busy, byte_ready, error}, 32'd0);
    check({tag, "_hdr"}, {29'd0, is_chr_ram, mirroring_mode, prg_single_bank},
          {29'd0, chr_ram, mirror, single});
    check({tag, "_q_empty"}, exp_q.size(), 32'd0);
    // Trailing bytes must be left on the source.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    #1;
    check({tag, "_trail_rdy"}, {31'd0, byte_ready}, 32'd0);
    repeat (2) @(negedge CLK);
    byte_valid = 1'b0;
    check({tag, "_still_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic err_test(input string tag, input logic [127:0] h, input int n, input logic [2:0] code);
    pulse_start();
    send_header(h, n, 1'b0);
    byte_valid = 1'b1;
    #1;
    check({tag, "_err"}, {28'd0, error, error_code}, {28'd0, 1'b1, code});
    check({tag, "_rdy"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_state"}, {28'd0, nes_reset, nes_enable, busy, done}, {28'd0, 4'b1000});
    @(negedge CLK);
    byte_valid = 1'b0;
  endtask

  initial begin
    RESET      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #2;
    check_reset_vals("por");
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    byte_valid = 1'b1;
    #1;
    check("idle_rdy", {31'd0, byte_ready}, 32'd0);
    @(negedge CLK);
    byte_valid = 1'b0;

    err_test("bad_magic", H_BADMAG, 3, 3'd1);
    err_test("prg3", H_PRG3, 16, 3'd2);
    err_test("chr2", H_CHR2, 16, 3'd3);
    err_test("mapper", H_MAPPER, 16, 3'd4);
    err_test("prio", H_PRIO, 16, 3'd2);

    // Gapped NROM-256 load, aborted by start in PRG at 0x1234 with a byte offered.
    pulse_start();
    send_header(H_NROM256, 16, 1'b1);
    send_prg(16'h1234, 1'b1);
    check("abort_pre_mirror", {31'd0, mirroring_mode}, 32'd1);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = prg_byte(16'h1234);
    #1;
    check("abort_rdy_during_start", {31'd0, byte_ready}, 32'd0);
    @(negedge CLK);
    start      = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("abort_flags", {26'd0, is_chr_ram, mirroring_mode, prg_single_bank, done, error, nes_enable},
          32'd0);
    check("abort_header_state", {29'd0, nes_reset, busy, byte_ready}, {29'd0, 3'b111});
    check("abort_q_empty", exp_q.size(), 32'd0);

    // Full gapless NROM-256 reload.
    send_header(H_NROM256, 16, 1'b0);
    send_prg(32768, 1'b0);
    send_chr(8192, 1'b0);
    byte_valid = 1'b0;
    check_done("nrom256", 1'b0, 1'b1, 1'b0);

    // NROM-128, CHR RAM, 512-byte trainer.
    pulse_start();
    send_header(H_TRAINER, 16, 1'b0);
    send_trainer();
    send_prg(16384, 1'b0);
    byte_valid = 1'b0;
    check_done("trainer", 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of CHR.
    pulse_start();
    send_header(H_NROM128, 16, 1'b0);
    send_prg(16384, 1'b0);
    send_chr(100, 1'b0);
    check("mid_chr_busy", {31'd0, busy}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    check_reset_vals("mid_chr_rst");
    byte_valid = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
